// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: burst/response encodings, the read FSM
// state type and the burst-length limit used by the read slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_BURST_LEN = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

  // Wrapping bursts are only meaningful for power-of-two beat counts
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_r_skid.sv
// Two-entry R-channel buffer. Entry 0 is the head and drives the R outputs
// directly from registers; entry 1 absorbs the beat that is already in flight
// from memory when the master stalls.
module axi_r_skid #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] push_id,
  input  logic [31:0]     push_data,
  input  logic [1:0]      push_resp,
  input  logic            push_last,
  output logic [1:0]      count,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid
);

  localparam int BW = ID_W + 35;

  logic [BW-1:0] head;
  logic [BW-1:0] spare;
  logic [BW-1:0] in_beat;
  logic          do_pop;

  assign in_beat = {push_id, push_data, push_resp, push_last};
  assign do_pop  = pop & (count != 2'd0);
  assign {rid, rdata, rresp, rlast} = head;
  assign rvalid  = (count != 2'd0);

  // Shift the spare into the head on a pop; an empty head is cleared so idle R outputs read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      spare <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= in_beat;
          else               spare <= in_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= spare;
          else               head <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head  <= spare;
            spare <= in_beat;
          end else begin
            head <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_read_slave.sv
// AXI3 read responder in front of a 1-cycle-latency single-port memory.
// Accepts one AR at a time, walks FIXED/INCR (and optionally WRAP) burst
// addresses and streams R beats through a 2-entry buffer at one beat per cycle.
// Build option: define AXI_RD_WRAP_EN to serve WRAP bursts; without it every
// WRAP request is answered as an error burst.
module axi_burst_read_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  rd_state_t         state;
  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        cur_burst;
  logic              cur_err;
  logic [7:0]        issue_cnt;
  logic              issue_pending;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic [2:0]        fill;
  logic              pop;
  logic              issue;
  logic              req_err;
  logic              unused_addr_bits;
`ifdef AXI_RD_WRAP_EN
  logic [7:0]        cur_len;
  logic [ADDR_W-1:0] wrap_mask;
`endif

  assign unused_addr_bits = ^{araddr[31:ADDR_W+2], araddr[1:0]};

  assign arready = (state == ST_IDLE) & ~rst;
  assign pop     = rvalid & rready;

  // Beats held in the buffer plus the one coming back from memory, net of this cycle's pop
  assign fill  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~rst & (state == ST_BURST) & issue_pending & (fill < 3'd2);

  assign mem_en   = issue & ~cur_err;
  assign mem_addr = cur_addr;

  // Classify the incoming request; anything unsupported becomes an error burst of len+1 beats
  always_comb begin
    req_err = 1'b0;
    if (arsize != 3'd2) req_err = 1'b1;
    if (arlen > 8'(MAX_BURST_LEN)) req_err = 1'b1;
    case (arburst)
      BURST_FIXED, BURST_INCR: ;
`ifdef AXI_RD_WRAP_EN
      BURST_WRAP: if (!wrap_len_ok(arlen)) req_err = 1'b1;
`else
      BURST_WRAP: req_err = 1'b1;
`endif
      default: req_err = 1'b1;
    endcase
  end

`ifdef AXI_RD_WRAP_EN
  assign wrap_mask = ADDR_W'(cur_len[3:0]);
`endif

  // Address of the beat after the one being issued now
  always_comb begin
    next_addr = cur_addr;
    case (cur_burst)
      BURST_INCR: next_addr = cur_addr + ADDR_W'(1);
`ifdef AXI_RD_WRAP_EN
      BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + ADDR_W'(1)) & wrap_mask);
`endif
      default: next_addr = cur_addr;
    endcase
  end

  // Burst sequencer: latch the request, issue reads, and return to idle when the last beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_id        <= '0;
      cur_addr      <= '0;
      cur_burst     <= BURST_FIXED;
      cur_err       <= 1'b0;
      issue_cnt     <= 8'd0;
      issue_pending <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
`ifdef AXI_RD_WRAP_EN
      cur_len       <= 8'd0;
`endif
    end else begin
      inflight      <= issue;
      inflight_last <= issue & (issue_cnt == 8'd0);
      case (state)
        ST_IDLE: begin
          if (arvalid) begin
            cur_id        <= arid;
            cur_addr      <= araddr[ADDR_W+1:2];
            cur_burst     <= arburst;
            cur_err       <= req_err;
            issue_cnt     <= arlen;
            issue_pending <= 1'b1;
`ifdef AXI_RD_WRAP_EN
            cur_len       <= arlen;
`endif
            state         <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            cur_addr <= next_addr;
            if (issue_cnt == 8'd0) issue_pending <= 1'b0;
            else                   issue_cnt     <= issue_cnt - 8'd1;
          end
          if (pop & rlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_r_skid #(.ID_W(ID_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (pop),
    .push_id   (cur_id),
    .push_data (cur_err ? 32'd0 : mem_rdata),
    .push_resp (cur_err ? RESP_SLVERR : RESP_OKAY),
    .push_last (inflight_last),
    .count     (occ),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid)
  );

endmodule
